// File: rtl/prog_loader.sv
// prog_loader: parses an A5 / LEN_HI / LEN_LO / word-stream frame and writes 16-bit words into instruction RAM,
// holding the CPU in reset until the frame completes. Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
  parameter int unsigned       ADDR_W = 16,
  parameter int unsigned       DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR} state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] len_word;
  logic        last_word;

  assign xfer      = in_valid & in_ready_q;
  assign len_word  = {len_q[15:8], in_data};
  assign last_word = ((32'(index_q) + 32'd1) == 32'(len_q));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    index_d     = index_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    // start wins over a byte transfer arriving in the same cycle
    if (start) begin
      state_d = IDLE;
      index_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
      if (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO}) csum_d = csum_q ^ in_data;
`endif
      case (state_q)
        IDLE: begin
          if (in_data == 8'hA5) state_d = LEN_HI;
        end
        LEN_HI: begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d   = len_word;
          index_d = '0;
          if (len_word == 16'd0)           state_d = END_ST;
          else if (32'(len_word) > DEPTH)  state_d = ERR;
          else                             state_d = DATA_HI;
        end
        DATA_HI: begin
          hi_d    = in_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE + index_q;
          mem_wdata_d = {hi_q, in_data};
          index_d     = index_q + ADDR_W'(1);
          state_d     = last_word ? END_ST : DATA_HI;
        end
        CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = (in_data == csum_q) ? DONE : ERR;
`else
          state_d = ERR;
`endif
        end
        default: state_d = state_q;
      endcase
    end
    // status outputs are registered copies of the next state
    in_ready_d = !(state_d inside {DONE, ERR});
    cpu_hold_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      index_q     <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      index_q     <= index_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
